// File: rtl/send_file_pkg.sv
// Shared definitions for the UART file transfer pair: control bytes, FSM states,
// and the nibble-to-ASCII helper that both ends agree on.
package send_file_pkg;

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] SOT = 8'h02;
  localparam logic [7:0] EOT = 8'h03;
  localparam logic [7:0] EOF = 8'h04;
  localparam logic [7:0] ACK = 8'h06;

  typedef enum logic [3:0] {
    IDLE,
    SEND_SOH,
    WAIT_ACK_SOH,
    SEND_REG,
    SEND_EOT,
    WAIT_ACK_EOT,
    SEND_SOT,
    WAIT_ACK_SOT,
    SEND_CONT,
    SEND_EOF,
    WAIT_ACK_EOF,
    DONE
  } state_e;

  // Uppercase hex: 0-9 -> '0'-'9', A-F -> 'A'-'F'
  function automatic logic [7:0] to_hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] ctrl_char(input state_e s);
    case (s)
      SEND_SOH: return SOH;
      SEND_EOT: return EOT;
      SEND_SOT: return SOT;
      SEND_EOF: return EOF;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic state_e wait_of(input state_e s);
    case (s)
      SEND_SOH: return WAIT_ACK_SOH;
      SEND_EOT: return WAIT_ACK_EOT;
      SEND_SOT: return WAIT_ACK_SOT;
      SEND_EOF: return WAIT_ACK_EOF;
      default:  return IDLE;
    endcase
  endfunction

  function automatic state_e resend_of(input state_e s);
    case (s)
      WAIT_ACK_SOH: return SEND_SOH;
      WAIT_ACK_EOT: return SEND_EOT;
      WAIT_ACK_SOT: return SEND_SOT;
      WAIT_ACK_EOF: return SEND_EOF;
      default:      return IDLE;
    endcase
  endfunction

  function automatic state_e after_ack(input state_e s);
    case (s)
      WAIT_ACK_SOH: return SEND_REG;
      WAIT_ACK_EOT: return SEND_SOT;
      WAIT_ACK_SOT: return SEND_CONT;
      WAIT_ACK_EOF: return DONE;
      default:      return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/data_fifo_oneclk.sv
// Single-clock first-word-fall-through FIFO; dout shows the head whenever not empty.
module data_fifo_oneclk #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic do_wr, do_rd;

  assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/send_file.sv
// UART file transmitter: handshakes SOH, register hex, SOT, payload stream and EOF
// with the remote receiver, resending each control char on ACK timeout.
module send_file
  import send_file_pkg::*;
#(
  parameter logic [31:0] ACK_TIMEOUT = 32'd1_000_000,
  parameter logic [3:0]  MAX_RETRY   = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] state,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_pointer,
  input  logic [7:0] send_fifo_din,
  input  logic       send_fifo_we,
  output logic       send_fifo_full,
  input  logic       send_eof,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_din,
  output logic       tx_write_en,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  output logic       rx_read_en,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] timer_q, timer_d;
  logic        eof_req_q, eof_req_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        error_q, error_d;

  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        ack_seen;
  logic [7:0]  hex_digit;

  data_fifo_oneclk #(.WIDTH(8), .DEPTH_LOG2(4)) u_payload_fifo (
    .clk   (clk),
    .rst   (~reset),
    .din   (send_fifo_din),
    .wr_en (send_fifo_we & ~send_fifo_full),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .full  (send_fifo_full),
    .empty (fifo_empty)
  );

  assign ack_seen = rx_data_rdy & (rx_data == ACK);
  assign state    = state_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign error    = error_q;

  always_comb begin
    case (cnt_q)
      2'd0:    hex_digit = to_hex_char(addr_q[7:4]);
      2'd1:    hex_digit = to_hex_char(addr_q[3:0]);
      2'd2:    hex_digit = to_hex_char(ptr_q[7:4]);
      default: hex_digit = to_hex_char(ptr_q[3:0]);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    eof_req_d   = eof_req_q | (send_eof & (state_q != IDLE));
    addr_d      = addr_q;
    ptr_d       = ptr_q;
    error_d     = 1'b0;
    tx_din      = 8'h00;
    tx_write_en = 1'b0;
    rx_read_en  = 1'b0;
    fifo_rd     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND_SOH;
          addr_d    = reg_addr;
          ptr_d     = reg_pointer;
          eof_req_d = 1'b0;
          retry_d   = '0;
          cnt_d     = '0;
        end
      end
      SEND_SOH, SEND_EOT, SEND_SOT, SEND_EOF: begin
        tx_din      = ctrl_char(state_q);
        tx_write_en = ~tx_fifo_full;
        if (!tx_fifo_full) begin
          state_d = wait_of(state_q);
          timer_d = '0;
        end
      end
      SEND_REG: begin
        tx_din      = hex_digit;
        tx_write_en = ~tx_fifo_full;
        if (!tx_fifo_full) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = SEND_EOT;
        end
      end
      WAIT_ACK_SOH, WAIT_ACK_EOT, WAIT_ACK_SOT, WAIT_ACK_EOF: begin
        // Non-ACK bytes are popped and dropped; an ACK on the timeout cycle still counts
        rx_read_en = rx_data_rdy;
        timer_d    = timer_q + 32'd1;
        if (ack_seen) begin
          state_d = after_ack(state_q);
          retry_d = '0;
        end else if (timer_q == ACK_TIMEOUT - 32'd1) begin
          if (retry_q < MAX_RETRY) begin
            retry_d = retry_q + 4'd1;
            state_d = resend_of(state_q);
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      SEND_CONT: begin
        tx_din      = fifo_dout;
        fifo_rd     = ~fifo_empty & ~tx_fifo_full;
        tx_write_en = fifo_rd;
        if (eof_req_q && fifo_empty) state_d = SEND_EOF;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      eof_req_q <= 1'b0;
      addr_q    <= '0;
      ptr_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      eof_req_q <= eof_req_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_send_file.sv
// Self-checking bench for send_file: a host model ACKs control chars and the
// observed tx stream is compared against the byte sequence built from the protocol rules.
module tb_send_file;

  localparam int ST_IDLE = 0, ST_SEND_REG = 3, ST_WAIT_ACK_SOT = 7, ST_SEND_CONT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic       start;
  logic [7:0] reg_addr, reg_pointer;
  logic [7:0] send_fifo_din;
  logic       send_fifo_we, send_fifo_full;
  logic       send_eof;
  logic       tx_fifo_full;
  logic [7:0] tx_din;
  logic       tx_write_en;
  logic [7:0] rx_data;
  logic       rx_data_rdy;
  logic       rx_read_en;
  logic       busy, done, error;

  always #5 clk = ~clk;

  send_file #(.ACK_TIMEOUT(32'd16), .MAX_RETRY(4'd3)) dut (
    .clk(clk), .reset(reset), .state(state), .start(start),
    .reg_addr(reg_addr), .reg_pointer(reg_pointer),
    .send_fifo_din(send_fifo_din), .send_fifo_we(send_fifo_we), .send_fifo_full(send_fifo_full),
    .send_eof(send_eof), .tx_fifo_full(tx_fifo_full), .tx_din(tx_din), .tx_write_en(tx_write_en),
    .rx_data(rx_data), .rx_data_rdy(rx_data_rdy), .rx_read_en(rx_read_en),
    .busy(busy), .done(done), .error(error)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Host side model state
  logic [7:0] tx_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];
  int  done_cnt, err_cnt, viol_cnt, pop_cnt;
  bit  ack_en = 1'b1;
  int  junk_n = 0;
  bit  junk_fixed = 1'b0;
  bit  rx_flush = 1'b0;
  bit  ack_pending = 1'b0;
  int  ack_delay = 0;
  bit  pop_now = 1'b0;

  always begin
    @(negedge clk);
    pop_now = 1'b0;
    if (reset) begin
      if (tx_write_en) begin
        if (tx_fifo_full) viol_cnt++;
        tx_log.push_back(tx_din);
        if (ack_en && (tx_din inside {8'h01, 8'h02, 8'h03, 8'h04})) begin
          ack_pending = 1'b1;
          ack_delay   = $urandom_range(0, 4);
        end
      end
      if (rx_read_en) begin
        pop_now = 1'b1;
        pop_cnt++;
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
    end
    @(posedge clk);
    #1;
    if (rx_flush) begin
      rx_q.delete();
      ack_pending = 1'b0;
      rx_flush    = 1'b0;
    end else begin
      if (pop_now && rx_q.size() > 0) void'(rx_q.pop_front());
      if (ack_pending) begin
        if (ack_delay == 0) begin
          for (int j = 0; j < junk_n; j++)
            rx_q.push_back(junk_fixed ? 8'h15 : 8'($urandom_range(8'h07, 8'hFF)));
          rx_q.push_back(8'h06);
          ack_pending = 1'b0;
        end else begin
          ack_delay--;
        end
      end
    end
    rx_data_rdy = (rx_q.size() != 0);
    rx_data     = rx_data_rdy ? rx_q[0] : 8'h00;
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  // Expected wire sequence for one full transfer
  task automatic build_expect(input logic [7:0] a, input logic [7:0] p);
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(hexc(a[7:4]));
    exp_q.push_back(hexc(a[3:0]));
    exp_q.push_back(hexc(p[7:4]));
    exp_q.push_back(hexc(p[3:0]));
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h02);
    foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
    exp_q.push_back(8'h04);
  endtask

  task automatic compare_stream(input string name);
    check({name, ".len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s.byte[%0d]", name, i),
            (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF, 32'(exp_q[i]));
  endtask

  function automatic int count_byte(input logic [7:0] b);
    int c = 0;
    foreach (tx_log[i]) if (tx_log[i] == b) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    done_cnt = 0; err_cnt = 0; viol_cnt = 0; pop_cnt = 0;
    rx_flush = 1'b1;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    send_fifo_din = b;
    send_fifo_we  = 1'b1;
    tick();
    send_fifo_we  = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] p);
    reg_addr = a; reg_pointer = p; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_eof();
    send_eof = 1'b1;
    tick();
    send_eof = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int c = 0;
    while (state != 4'(s) && c < budget) begin
      tick();
      c++;
    end
    check(tag, state, s);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == 0 && err_cnt == 0 && c < budget) begin
      tick();
      c++;
    end
    repeat (3) tick();
  endtask

  task automatic finish_checks(input string name);
    compare_stream(name);
    check({name, ".done_pulses"}, done_cnt, 1);
    check({name, ".error_pulses"}, err_cnt, 0);
    check({name, ".write_while_full"}, viol_cnt, 0);
    check({name, ".rx_drained"}, rx_q.size(), 0);
    check({name, ".busy_after"}, busy, 0);
  endtask

  task automatic run_random(input int idx);
    int n, k, pushed, cyc;
    bit eof_sent;
    logic [7:0] a, p;
    n = $urandom_range(0, 8);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(8'h07, 8'hFF)));
    a = 8'($urandom); p = 8'($urandom);
    junk_n = $urandom_range(0, 2); junk_fixed = 1'b0; ack_en = 1'b1;
    clear_logs();
    k = $urandom_range(0, n);
    for (int i = 0; i < k; i++) push_byte(pl_q[i]);
    pushed = k;
    do_start(a, p);
    eof_sent = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && err_cnt == 0 && cyc < 2000) begin
      tx_fifo_full = ($urandom_range(0, 3) == 0);
      if (pushed < n && $urandom_range(0, 1) == 1) begin
        send_fifo_din = pl_q[pushed];
        send_fifo_we  = 1'b1;
        pushed++;
      end
      if (!eof_sent && pushed == n && $urandom_range(0, 3) == 0) begin
        send_eof = 1'b1;
        eof_sent = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        start = 1'b1; reg_addr = 8'($urandom); reg_pointer = 8'($urandom);
      end
      tick();
      send_fifo_we = 1'b0; send_eof = 1'b0; start = 1'b0;
      cyc++;
    end
    tx_fifo_full = 1'b0;
    repeat (3) tick();
    build_expect(a, p);
    $display("xfer rand%0d: addr=%02h ptr=%02h payload=%0d junk=%0d tx_bytes=%0d",
             idx, a, p, n, junk_n, tx_log.size());
    finish_checks($sformatf("rand%0d", idx));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; reg_addr = '0; reg_pointer = '0;
    send_fifo_din = '0; send_fifo_we = 1'b0; send_eof = 1'b0;
    tx_fifo_full = 1'b0; rx_data = '0; rx_data_rdy = 1'b0;
    done_cnt = 0; err_cnt = 0; viol_cnt = 0; pop_cnt = 0;
    repeat (3) tick();
    check("rst.state", state, ST_IDLE);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    check("rst.tx_write_en", tx_write_en, 0);
    check("rst.rx_read_en", rx_read_en, 0);
    check("rst.send_fifo_full", send_fifo_full, 0);
    reset = 1'b1;
    tick();

    // Reference transfer, with tx held full for 5 cycles in the middle of the hex digits
    ack_en = 1'b1; junk_n = 0;
    clear_logs();
    pl_q.delete(); pl_q.push_back(8'h41); pl_q.push_back(8'h42);
    push_byte(8'h41); push_byte(8'h42);
    do_start(8'h3A, 8'h7F);
    pulse_eof();
    wait_state(ST_SEND_REG, 60, "basic.reach_send_reg");
    tick();
    tx_fifo_full = 1'b1;
    repeat (5) tick();
    tx_fifo_full = 1'b0;
    wait_done(400);
    build_expect(8'h3A, 8'h7F);
    $display("xfer basic: addr=3a ptr=7f payload=2 tx_bytes=%0d", tx_log.size());
    finish_checks("basic");

    // Non-ACK bytes ahead of every ACK must be popped and ignored
    junk_n = 1; junk_fixed = 1'b1;
    clear_logs();
    pl_q.delete(); pl_q.push_back(8'h99);
    push_byte(8'h99);
    do_start(8'hC5, 8'h0E);
    pulse_eof();
    wait_done(400);
    build_expect(8'hC5, 8'h0E);
    $display("xfer junk: addr=c5 ptr=0e payload=1 tx_bytes=%0d pops=%0d", tx_log.size(), pop_cnt);
    finish_checks("junk");
    check("junk.pop_count", pop_cnt, 8);
    junk_n = 0; junk_fixed = 1'b0;

    // No ACK at all: one SOH plus three resends, then abort
    ack_en = 1'b0;
    clear_logs();
    do_start(8'h11, 8'h22);
    begin
      int c = 0;
      while (err_cnt == 0 && c < 300) begin tick(); c++; end
    end
    repeat (3) tick();
    $display("xfer timeout: tx_bytes=%0d error_pulses=%0d", tx_log.size(), err_cnt);
    check("timeout.soh_count", tx_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("timeout.byte[%0d]", i), (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF, 32'h01);
    check("timeout.error_pulses", err_cnt, 1);
    check("timeout.done_pulses", done_cnt, 0);
    check("timeout.state", state, ST_IDLE);
    check("timeout.busy", busy, 0);
    ack_en = 1'b1;

    // Reset while stalled in payload streaming with 3 bytes queued
    clear_logs();
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    do_start(8'h55, 8'h66);
    pulse_eof();
    wait_state(ST_WAIT_ACK_SOT, 80, "abort.reach_wait_sot");
    tx_fifo_full = 1'b1;
    wait_state(ST_SEND_CONT, 40, "abort.reach_send_cont");
    repeat (2) tick();
    reset = 1'b0;
    #2;
    check("abort.state", state, ST_IDLE);
    check("abort.busy", busy, 0);
    check("abort.send_fifo_full", send_fifo_full, 0);
    tx_fifo_full = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("abort.no_eof", count_byte(8'h04), 0);
    $display("xfer abort: tx_bytes=%0d", tx_log.size());

    // After the abort the payload FIFO must be empty; eof right after start gives SOT then EOF
    clear_logs();
    pl_q.delete();
    do_start(8'hE0, 8'h09);
    pulse_eof();
    wait_done(400);
    build_expect(8'hE0, 8'h09);
    $display("xfer empty: addr=e0 ptr=09 payload=0 tx_bytes=%0d", tx_log.size());
    finish_checks("empty");

    // send_eof in IDLE must not carry into the next transfer
    clear_logs();
    pulse_eof();
    do_start(8'h4B, 8'hD2);
    wait_state(ST_SEND_CONT, 80, "idle_eof.reach_send_cont");
    repeat (6) tick();
    check("idle_eof.still_streaming", state, ST_SEND_CONT);
    check("idle_eof.no_eof_yet", count_byte(8'h04), 0);
    pulse_eof();
    wait_done(200);
    build_expect(8'h4B, 8'hD2);
    $display("xfer idle_eof: addr=4b ptr=d2 payload=0 tx_bytes=%0d", tx_log.size());
    finish_checks("idle_eof");

    for (int t = 0; t < 6; t++) run_random(t);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
